md_ctrl: RTL and testbench

Issue and stall controller for the EX-stage multiply/divide unit of the 5-stage MIPS pipeline. It accepts decoded MD-class operations from EX, pulses a start to the HI/LO datapath, and tracks the busy window with a latency counter. It raises the pipeline stall for any MD-class instruction that arrives while the unit is busy, and gates issue on EX flush (exception or interrupt).

---
 rtl/md_pkg.sv | 51 +++++
 rtl/md_lat_counter.sv | 29 ++
 rtl/md_ctrl.sv | 126 ++++++++++++
 tb/tb_md_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and class-decode helpers for the EX-stage multiply/divide controller.
// Op encodings above MD_MTLO are illegal and decode as MD_NONE.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MADDU = 4'd6,
    MD_MSUB  = 4'd7,
    MD_MSUBU = 4'd8,
    MD_MFHI  = 4'd9,
    MD_MFLO  = 4'd10,
    MD_MTHI  = 4'd11,
    MD_MTLO  = 4'd12
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2
  } md_state_e;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;
  localparam int MD_CNT_W_DEF   = 4;

  function automatic logic [3:0] md_sanitize(input logic [3:0] op);
    return (op > MD_MTLO) ? MD_NONE : op;
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_move(input logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  function automatic logic is_read(input logic [3:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter; o_last flags the final busy cycle (count == 1), zero latency.
// Load wins over decrement; holds at zero; no backpressure.
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_ctrl.sv
// MD-unit issue/stall controller: start is combinational in the issue cycle, busy for LAT cycles after.
// MD ops stall while busy; optional MD_DIVZERO_FAST_EN retires divide-by-zero without a busy window.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF,
  parameter int CNT_W   = MD_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_flush,
  input  logic [3:0] md_op,
  input  logic       rt_zero,
  output logic       start,
  output logic [3:0] md_op_q,
  output logic       hilo_we,
  output logic       rd_en,
  output logic       busy,
  output logic       stall,
  output logic       done
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [3:0]       r_md_op_q;
  logic [3:0]       w_op;
  logic             w_act;
  logic             w_busy;
  logic             w_start;
  logic             w_hilo_we;
  logic             w_rd_en;
  logic             w_stall;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_last;
  logic             w_divzero_fast;

  assign w_op   = md_sanitize(md_op);
  assign w_act  = ex_valid & ~ex_flush & (w_op != MD_NONE);
  assign w_busy = (r_state != ST_IDLE);

`ifdef MD_DIVZERO_FAST_EN
  assign w_divzero_fast = is_div(w_op) & rt_zero;
`else
  logic w_unused_rt_zero;
  assign w_unused_rt_zero = rt_zero;
  assign w_divzero_fast   = 1'b0;
`endif

  md_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_cnt     (w_cnt),
    .o_last    (w_cnt_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_hilo_we   = 1'b0;
    w_rd_en     = 1'b0;
    w_stall     = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_act) begin
          if (is_arith(w_op)) begin
            w_start = 1'b1;
            // Divide-by-zero fast path: HI/LO stay unchanged, so nothing to wait for.
            if (!w_divzero_fast) begin
              w_load = 1'b1;
              if (is_div(w_op)) begin
                w_load_val  = CNT_W'(DIV_LAT);
                w_state_nxt = ST_DIV_BUSY;
              end else begin
                w_load_val  = CNT_W'(MUL_LAT);
                w_state_nxt = ST_MUL_BUSY;
              end
            end
          end else if (is_move(w_op)) begin
            w_hilo_we = 1'b1;
          end else if (is_read(w_op)) begin
            w_rd_en = 1'b1;
          end
        end
      end
      default: begin
        // Flush does not release the stall: the op in EX may be replaced, not dropped.
        w_stall = ex_valid & (w_op != MD_NONE);
        if (w_cnt_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_md_op_q <= MD_NONE;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_md_op_q <= w_op;
      end
    end
  end

  // The issuing op is forwarded so md_op_q is meaningful in the start cycle itself.
  assign start   = w_start & ~reset;
  assign md_op_q = reset ? MD_NONE : (w_start ? w_op : r_md_op_q);
  assign hilo_we = w_hilo_we & ~reset;
  assign rd_en   = w_rd_en & ~reset;
  assign busy    = w_busy & ~reset;
  assign stall   = w_stall & ~reset;
  assign done    = w_busy & w_cnt_last & ~reset;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl; outputs packed as {start,hilo_we,rd_en,busy,stall,done}.
module tb_md_ctrl;
  import md_pkg::*;

  logic       clk;
  logic       reset;
  logic       ex_valid;
  logic       ex_flush;
  logic [3:0] md_op;
  logic       rt_zero;
  logic       start;
  logic [3:0] md_op_q;
  logic       hilo_we;
  logic       rd_en;
  logic       busy;
  logic       stall;
  logic       done;
  logic [5:0] w_outs;

  int n_run;
  int n_fail;

  md_ctrl u_dut (
    .clk     (clk),
    .reset   (reset),
    .ex_valid(ex_valid),
    .ex_flush(ex_flush),
    .md_op   (md_op),
    .rt_zero (rt_zero),
    .start   (start),
    .md_op_q (md_op_q),
    .hilo_we (hilo_we),
    .rd_en   (rd_en),
    .busy    (busy),
    .stall   (stall),
    .done    (done)
  );

  assign w_outs = {start, hilo_we, rd_en, busy, stall, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic drive(input logic rs, input logic v, input logic f,
                       input logic [3:0] op, input logic rz);
    @(negedge clk);
    reset    = rs;
    ex_valid = v;
    ex_flush = f;
    md_op    = op;
    rt_zero  = rz;
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b0, MD_MULT, 1'b0);
      n_run++;
      if (w_outs !== 6'b000000 || md_op_q !== 4'd0) begin
        n_fail++;
        $display("FAIL reset c%0d outs=%b md_op_q=%0d expected outs=000000 md_op_q=0", c, w_outs, md_op_q);
      end
    end
    drive(1'b0, 1'b0, 1'b0, MD_NONE, 1'b0);
    n_run++;
    if (w_outs !== 6'b000000 || md_op_q !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_after outs=%b md_op_q=%0d expected outs=000000 md_op_q=0", w_outs, md_op_q);
    end
  endtask

  task automatic test_mult_mflo();
    logic [3:0] op;
    logic [5:0] e;
    for (int c = 0; c <= 6; c++) begin
      op = (c == 0) ? MD_MULT : MD_MFLO;
      e  = (c == 0) ? 6'b100000 : (c == 6) ? 6'b001000 : (c == 5) ? 6'b000111 : 6'b000110;
      drive(1'b0, 1'b1, 1'b0, op, 1'b0);
      n_run++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL mult_mflo c%0d outs=%b expected %b", c, w_outs, e);
      end
      if (c == 0 || c == 3) begin
        n_run++;
        if (md_op_q !== MD_MULT) begin
          n_fail++;
          $display("FAIL mult_md_op_q c%0d got %0d expected %0d", c, md_op_q, MD_MULT);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic       v;
    logic [5:0] e;
    for (int c = 0; c <= 22; c++) begin
      op = (c == 0) ? MD_DIVU : (c <= 11) ? MD_DIV : MD_NONE;
      v  = (c <= 11);
      if (c == 0 || c == 11)      e = 6'b100000;
      else if (c == 10)           e = 6'b000111;
      else if (c < 10)            e = 6'b000110;
      else if (c == 21)           e = 6'b000101;
      else if (c < 21)            e = 6'b000100;
      else                        e = 6'b000000;
      drive(1'b0, v, 1'b0, op, 1'b0);
      n_run++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL back_to_back c%0d outs=%b expected %b", c, w_outs, e);
      end
      if (c == 0 || c == 11) begin
        n_run++;
        if (md_op_q !== op) begin
          n_fail++;
          $display("FAIL b2b_md_op_q c%0d got %0d expected %0d", c, md_op_q, op);
        end
      end
    end
  endtask

  task automatic test_flush_issue();
    drive(1'b0, 1'b1, 1'b1, MD_MULT, 1'b0);
    n_run++;
    if (w_outs !== 6'b000000) begin
      n_fail++;
      $display("FAIL flush_issue outs=%b expected 000000", w_outs);
    end
    drive(1'b0, 1'b1, 1'b0, MD_MTHI, 1'b0);
    n_run++;
    if (w_outs !== 6'b010000) begin
      n_fail++;
      $display("FAIL flush_mthi outs=%b expected 010000", w_outs);
    end
    drive(1'b0, 1'b1, 1'b1, MD_MTLO, 1'b0);
    n_run++;
    if (w_outs !== 6'b000000) begin
      n_fail++;
      $display("FAIL flush_mtlo outs=%b expected 000000", w_outs);
    end
  endtask

  task automatic test_flush_busy();
    logic [3:0] op;
    logic       f;
    logic [5:0] e;
    int         n_done;
    n_done = 0;
    for (int c = 0; c <= 12; c++) begin
      op = (c == 0) ? MD_DIV : (c == 5) ? MD_MFHI : MD_NONE;
      f  = (c == 3 || c == 5);
      if (c == 0)       e = 6'b100000;
      else if (c == 5)  e = 6'b000110;
      else if (c == 10) e = 6'b000101;
      else if (c < 10)  e = 6'b000100;
      else              e = 6'b000000;
      drive(1'b0, 1'b1, f, op, 1'b0);
      if (done === 1'b1) n_done++;
      n_run++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL flush_busy c%0d outs=%b expected %b", c, w_outs, e);
      end
    end
    n_run++;
    if (n_done !== 1) begin
      n_fail++;
      $display("FAIL flush_busy_done_count got %0d expected 1", n_done);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] op;
    logic       rs;
    logic [5:0] e;
    int         n_done;
    n_done = 0;
    for (int c = 0; c <= 9; c++) begin
      op = (c == 0) ? MD_MADD : (c == 3) ? MD_MFHI : MD_NONE;
      rs = (c == 2);
      if (c == 0)      e = 6'b100000;
      else if (c == 1) e = 6'b000100;
      else if (c == 3) e = 6'b001000;
      else             e = 6'b000000;
      drive(rs, (c == 0 || c == 3), 1'b0, op, 1'b0);
      if (done === 1'b1) n_done++;
      n_run++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_op c%0d outs=%b expected %b", c, w_outs, e);
      end
    end
    n_run++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_op_done_count got %0d expected 0", n_done);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] op;
    logic [5:0] e;
    op = 4'd14;
    drive(1'b0, 1'b1, 1'b0, op, 1'b0);
    n_run++;
    if (w_outs !== 6'b000000) begin
      n_fail++;
      $display("FAIL illegal_idle outs=%b expected 000000", w_outs);
    end
    for (int c = 0; c <= 6; c++) begin
      op = (c == 0) ? MD_MULTU : 4'd15;
      if (c == 0)      e = 6'b100000;
      else if (c == 5) e = 6'b000101;
      else if (c < 5)  e = 6'b000100;
      else             e = 6'b000000;
      drive(1'b0, 1'b1, 1'b0, op, 1'b0);
      n_run++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL illegal_busy c%0d outs=%b expected %b", c, w_outs, e);
      end
    end
  endtask

  task automatic test_divzero();
    logic [5:0] e;
`ifdef MD_DIVZERO_FAST_EN
    for (int c = 0; c <= 2; c++) begin
      e = (c == 0) ? 6'b100000 : 6'b000000;
      drive(1'b0, (c == 0), 1'b0, (c == 0) ? MD_DIVU : MD_NONE, 1'b1);
      n_run++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL divzero_fast c%0d outs=%b expected %b", c, w_outs, e);
      end
    end
`else
    for (int c = 0; c <= 11; c++) begin
      if (c == 0)       e = 6'b100000;
      else if (c == 10) e = 6'b000101;
      else if (c < 10)  e = 6'b000100;
      else              e = 6'b000000;
      drive(1'b0, (c == 0), 1'b0, (c == 0) ? MD_DIV : MD_NONE, 1'b1);
      n_run++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL divzero_full c%0d outs=%b expected %b", c, w_outs, e);
      end
    end
`endif
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ex_valid = 1'b0;
    ex_flush = 1'b0;
    md_op    = MD_NONE;
    rt_zero  = 1'b0;
    test_reset();
    test_mult_mflo();
    test_back_to_back();
    test_flush_issue();
    test_flush_busy();
    test_reset_mid_op();
    test_illegal();
    test_divzero();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not complete, tests_run=%0d failed=%0d", n_run, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
